// File: rtl/claw_pkg.sv
// claw_pkg: shared state encoding, output bundle and default timing for the claw game sequencer.
package claw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_DROP    = 3'd2,
    ST_GRAB    = 3'd3,
    ST_LIFT    = 3'd4,
    ST_HOME    = 3'd5,
    ST_RELEASE = 3'd6,
    ST_FAULT   = 3'd7
  } claw_state_e;

  typedef struct packed {
    logic x_fwd;
    logic x_bwd;
    logic y_fwd;
    logic y_bwd;
    logic z_down;
    logic z_up;
    logic grip;
    logic fault;
  } claw_out_t;

  localparam int DEF_TICK_DIV     = 100000;
  localparam int DEF_PLAY_TICKS   = 20000;
  localparam int DEF_DROP_TICKS   = 1500;
  localparam int DEF_GRIP_TICKS   = 500;
  localparam int DEF_HOME_TIMEOUT = 10000;

  localparam int SYNC_DEPTH = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/claw_timer.sv
// claw_timer: TICK_DIV prescaler (down-counter) feeding an elapsed-tick counter.
// A synchronous clear restarts both so every state starts timing from zero.
module claw_timer #(
  parameter int TICK_DIV = 100000,
  parameter int TICK_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic              tick,
  output logic [TICK_W-1:0] elapsed_ticks
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;

  // tick is high in the last cycle of each TICK_DIV window
  assign tick = (pre_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre_cnt       <= PRE_LOAD;
      elapsed_ticks <= '0;
    end else if (tick) begin
      pre_cnt       <= PRE_LOAD;
      elapsed_ticks <= elapsed_ticks + 1'b1;
    end else begin
      pre_cnt <= pre_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/claw_game_sequencer.sv
// claw_game_sequencer: one-game sequencer for the claw machine (coin, play, drop, grab, lift, home, release).
// Define CLAW_PLAY_TIMER_EN to also end PLAY after PLAY_TICKS ticks.
//
// state   | meaning
// IDLE    | waiting for coin, all outputs low
// PLAY    | player drives X/Y, btn_drop ends play
// DROP    | z_down for DROP_TICKS
// GRAB    | gripper closing for GRIP_TICKS
// LIFT    | z_up until lim_z, bounded by HOME_TIMEOUT
// HOME    | x_bwd/y_bwd until both limits, bounded by HOME_TIMEOUT
// RELEASE | gripper open for GRIP_TICKS
// FAULT   | lift/home timeout, left only by reset
module claw_game_sequencer
  import claw_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int PLAY_TICKS   = DEF_PLAY_TICKS,
  parameter int DROP_TICKS   = DEF_DROP_TICKS,
  parameter int GRIP_TICKS   = DEF_GRIP_TICKS,
  parameter int HOME_TIMEOUT = DEF_HOME_TIMEOUT
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       coin,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fwd,
  input  logic       btn_back,
  input  logic       btn_drop,
  input  logic       lim_x,
  input  logic       lim_y,
  input  logic       lim_z,
  output logic       x_fwd,
  output logic       x_bwd,
  output logic       y_fwd,
  output logic       y_bwd,
  output logic       z_down,
  output logic       z_up,
  output logic       grip,
  output logic [2:0] state_o,
  output logic       fault
);

  localparam int TICK_MAX = max_int(max_int(PLAY_TICKS, DROP_TICKS), max_int(GRIP_TICKS, HOME_TIMEOUT));
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam logic [TICK_W-1:0] DROP_LAST    = TICK_W'(DROP_TICKS - 1);
  localparam logic [TICK_W-1:0] GRIP_LAST    = TICK_W'(GRIP_TICKS - 1);
  localparam logic [TICK_W-1:0] TIMEOUT_LAST = TICK_W'(HOME_TIMEOUT - 1);
  localparam int NSYNC = 8;

  logic [NSYNC-1:0] raw_in;
  logic [NSYNC-1:0] sync_q [SYNC_DEPTH];
  logic s_left, s_right, s_fwd, s_back, s_drop, s_lim_x, s_lim_y, s_lim_z;

  claw_state_e state_q, state_nxt;
  claw_out_t   outs_q, outs_nxt;

  logic              tick;
  logic [TICK_W-1:0] elapsed_ticks;
  logic              drop_done, grip_done, timeout_done;

  assign raw_in = {btn_left, btn_right, btn_fwd, btn_back, btn_drop, lim_x, lim_y, lim_z};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {s_left, s_right, s_fwd, s_back, s_drop, s_lim_x, s_lim_y, s_lim_z} = sync_q[SYNC_DEPTH-1];

  claw_timer #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_timer (
    .clk           (CLK100MHZ),
    .reset         (reset),
    .clr           (state_nxt != state_q),
    .tick          (tick),
    .elapsed_ticks (elapsed_ticks)
  );

  // "done" fires in the final cycle of an N-tick window, so the next state starts on N*TICK_DIV
  assign drop_done    = tick && (elapsed_ticks == DROP_LAST);
  assign grip_done    = tick && (elapsed_ticks == GRIP_LAST);
  assign timeout_done = tick && (elapsed_ticks == TIMEOUT_LAST);

`ifdef CLAW_PLAY_TIMER_EN
  localparam logic [TICK_W-1:0] PLAY_LAST = TICK_W'(PLAY_TICKS - 1);
  logic play_done;
  assign play_done = tick && (elapsed_ticks == PLAY_LAST);
`endif

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:    if (coin) state_nxt = ST_PLAY;
`ifdef CLAW_PLAY_TIMER_EN
      ST_PLAY:    if (s_drop || play_done) state_nxt = ST_DROP;
`else
      ST_PLAY:    if (s_drop) state_nxt = ST_DROP;
`endif
      ST_DROP:    if (drop_done) state_nxt = ST_GRAB;
      ST_GRAB:    if (grip_done) state_nxt = ST_LIFT;
      ST_LIFT: begin
        if (s_lim_z)           state_nxt = ST_HOME;
        else if (timeout_done) state_nxt = ST_FAULT;
      end
      ST_HOME: begin
        if (s_lim_x && s_lim_y) state_nxt = ST_RELEASE;
        else if (timeout_done)  state_nxt = ST_FAULT;
      end
      ST_RELEASE: if (grip_done) state_nxt = ST_IDLE;
      ST_FAULT:   state_nxt = ST_FAULT;
    endcase

    // outputs follow the state being entered so both change on the same edge
    outs_nxt = '0;
    case (state_nxt)
      ST_PLAY: begin
        outs_nxt.x_fwd = s_right && !s_left;
        outs_nxt.x_bwd = s_left && !s_right && !s_lim_x;
        outs_nxt.y_fwd = s_fwd && !s_back;
        outs_nxt.y_bwd = s_back && !s_fwd && !s_lim_y;
      end
      ST_DROP:  outs_nxt.z_down = 1'b1;
      ST_GRAB:  outs_nxt.grip = 1'b1;
      ST_LIFT: begin
        outs_nxt.grip = 1'b1;
        outs_nxt.z_up = !s_lim_z;
      end
      ST_HOME: begin
        outs_nxt.grip  = 1'b1;
        outs_nxt.x_bwd = !s_lim_x;
        outs_nxt.y_bwd = !s_lim_y;
      end
      ST_FAULT: outs_nxt.fault = 1'b1;
      default:  outs_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= ST_IDLE;
      outs_q  <= '0;
    end else begin
      state_q <= state_nxt;
      outs_q  <= outs_nxt;
    end
  end

  assign state_o = state_q;
  assign x_fwd   = outs_q.x_fwd;
  assign x_bwd   = outs_q.x_bwd;
  assign y_fwd   = outs_q.y_fwd;
  assign y_bwd   = outs_q.y_bwd;
  assign z_down  = outs_q.z_down;
  assign z_up    = outs_q.z_up;
  assign grip    = outs_q.grip;
  assign fault   = outs_q.fault;

endmodule

// File: tb/tb_claw_game_sequencer.sv
// tb_claw_game_sequencer: table vectors, randomized play against a delayed rule model, and multi-cycle game sequences.
module tb_claw_game_sequencer;

  localparam int TICK_DIV = 4, PLAY_TICKS = 10, DROP_TICKS = 3, GRIP_TICKS = 2, HOME_TIMEOUT = 20;
  localparam int B_XF = 0, B_XB = 1, B_YF = 2, B_YB = 3, B_ZD = 4, B_ZU = 5, B_GRIP = 6, B_FAULT = 7;

  logic clk = 1'b0;
  logic reset = 1'b0, coin = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_fwd = 1'b0, btn_back = 1'b0, btn_drop = 1'b0;
  logic lim_x = 1'b0, lim_y = 1'b0, lim_z = 1'b0;
  logic x_fwd, x_bwd, y_fwd, y_bwd, z_down, z_up, grip, fault;
  logic [2:0] state_o;
  logic [7:0] outs;

  assign outs = {fault, grip, z_up, z_down, y_bwd, y_fwd, x_bwd, x_fwd};

  claw_game_sequencer #(
    .TICK_DIV(TICK_DIV), .PLAY_TICKS(PLAY_TICKS), .DROP_TICKS(DROP_TICKS),
    .GRIP_TICKS(GRIP_TICKS), .HOME_TIMEOUT(HOME_TIMEOUT)
  ) dut (
    .CLK100MHZ(clk), .reset(reset), .coin(coin),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fwd(btn_fwd), .btn_back(btn_back), .btn_drop(btn_drop),
    .lim_x(lim_x), .lim_y(lim_y), .lim_z(lim_z),
    .x_fwd(x_fwd), .x_bwd(x_bwd), .y_fwd(y_fwd), .y_bwd(y_bwd), .z_down(z_down), .z_up(z_up),
    .grip(grip), .state_o(state_o), .fault(fault)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int n, hi, cnt;
  logic [5:0] rv, ro;
  logic [5:0] hist[$];

  typedef struct packed {
    logic l, r, f, b, lx, ly;
    logic [3:0] exp_cmd;  // {y_bwd, y_fwd, x_bwd, x_fwd}
  } play_vec_t;
  play_vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts consecutive cycles spent in st (including the current one) and how many had outs[bidx] high.
  task automatic dwell(input logic [2:0] st, input int budget, input int bidx, output int nc, output int hc);
    nc = 1;
    hc = int'(outs[bidx]);
    while (nc < budget) begin
      step();
      if (state_o != st) break;
      nc++;
      hc += int'(outs[bidx]);
    end
  endtask

  // Player rule for one axis: returns {away_cmd, toward_cmd}
  function automatic logic [1:0] axis_cmd(input logic toward, input logic away, input logic at_home);
    if (toward && away) return 2'b00;
    if (toward) return 2'b01;
    if (away && !at_home) return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive_play(input logic l, input logic r, input logic f, input logic b, input logic lx, input logic ly);
    btn_left = l; btn_right = r; btn_fwd = f; btn_back = b; lim_x = lx; lim_y = ly;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110};

    // reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_state", state_o, 0);
    check("reset_outs", outs, 0);

    // game 1: full path
    coin = 1'b1; step(); coin = 1'b0;
    check("g1_coin_play", state_o, 1);
    btn_right = 1'b1; cnt = 0;
    repeat (8) begin step(); cnt += int'(x_fwd); end
    btn_right = 1'b0; btn_drop = 1'b1;
    repeat (2) begin step(); cnt += int'(x_fwd); end
    check("g1_still_play", state_o, 1);
    step(); cnt += int'(x_fwd);
    btn_drop = 1'b0;
    check("g1_drop_entry", state_o, 2);
    check("g1_x_fwd_cycles", cnt, 8);
    dwell(3'd2, 100, B_ZD, n, hi);
    check("g1_drop_len", n, 12);
    check("g1_z_down_cycles", hi, 12);
    check("g1_grab_entry", state_o, 3);
    dwell(3'd3, 100, B_GRIP, n, hi);
    check("g1_grab_len", n, 8);
    check("g1_grab_grip", hi, 8);
    check("g1_lift_entry", state_o, 4);
    check("g1_lift_outs", outs, 8'h60);
    repeat (4) step();
    lim_z = 1'b1;
    repeat (2) step();
    check("g1_lift_hold", state_o, 4);
    step();
    check("g1_home_entry", state_o, 5);
    check("g1_home_outs", outs, 8'h4A);
    lim_x = 1'b1;
    repeat (3) step();
    check("g1_home_x_stop", outs, 8'h48);
    check("g1_home_state", state_o, 5);
    lim_y = 1'b1;
    repeat (3) step();
    check("g1_release_entry", state_o, 6);
    check("g1_release_outs", outs, 0);
    dwell(3'd6, 100, B_GRIP, n, hi);
    check("g1_release_len", n, 8);
    check("g1_release_grip", hi, 0);
    check("g1_back_idle", state_o, 0);
    repeat (5) step();
    check("g1_stay_idle", state_o, 0);

    // game 2: table vectors, random play, coin in DROP, limits already set
    lim_x = 1'b0; lim_y = 1'b0; lim_z = 1'b0;
    coin = 1'b1; step(); coin = 1'b0;
    check("g2_coin_play", state_o, 1);
    foreach (vecs[k]) begin
      drive_play(vecs[k].l, vecs[k].r, vecs[k].f, vecs[k].b, vecs[k].lx, vecs[k].ly);
      repeat (3) step();
      check($sformatf("vec%0d", k), outs[3:0], vecs[k].exp_cmd);
    end
    for (int i = 0; i < 60; i++) begin
      rv = 6'($urandom);
      drive_play(rv[5], rv[4], rv[3], rv[2], rv[1], rv[0]);
      hist.push_back(rv);
      step();
      if (i >= 2) begin
        ro = hist[i-2];
        check("rand_play", outs[3:0], {axis_cmd(ro[3], ro[2], ro[0]), axis_cmd(ro[4], ro[5], ro[1])});
      end
    end
    drive_play(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("g2_play_after_rand", state_o, 1);
    btn_drop = 1'b1; repeat (3) step(); btn_drop = 1'b0;
    check("g2_drop_entry", state_o, 2);
    coin = 1'b1; step(); coin = 1'b0;
    dwell(3'd2, 100, B_ZD, n, hi);
    check("g2_drop_rest_len", n, 11);
    check("g2_grab_entry", state_o, 3);
    lim_x = 1'b1; lim_y = 1'b1; lim_z = 1'b1;
    dwell(3'd3, 100, B_GRIP, n, hi);
    check("g2_grab_len", n, 8);
    dwell(3'd4, 100, B_ZU, n, hi);
    check("g2_lift_one_cycle", n, 1);
    check("g2_lift_no_z_up", hi, 0);
    check("g2_home_entry", state_o, 5);
    check("g2_home_outs", outs, 8'h40);
    dwell(3'd5, 100, B_XB, n, hi);
    check("g2_home_one_cycle", n, 1);
    check("g2_release_entry", state_o, 6);
    coin = 1'b1;
    dwell(3'd6, 100, B_GRIP, n, hi);
    check("g2_release_len", n, 8);
    check("g2_idle_entry", state_o, 0);
    step();
    check("g2_coin_held_restart", state_o, 1);
    coin = 1'b0;

    // game 3: limit arriving in the timeout cycle wins
    lim_x = 1'b0; lim_y = 1'b0; lim_z = 1'b0;
    btn_drop = 1'b1; repeat (3) step(); btn_drop = 1'b0;
    check("g3_drop_entry", state_o, 2);
    dwell(3'd2, 100, B_ZD, n, hi);
    check("g3_drop_len", n, 12);
    dwell(3'd3, 100, B_GRIP, n, hi);
    check("g3_grab_len", n, 8);
    lim_z = 1'b1;
    dwell(3'd4, 100, B_ZU, n, hi);
    check("g3_lift_len", n, 3);
    check("g3_lift_z_up", hi, 3);
    check("g3_home_entry", state_o, 5);
    repeat (77) step();
    lim_x = 1'b1; lim_y = 1'b1;
    repeat (2) step();
    check("g3_home_pre_timeout", state_o, 5);
    step();
    check("g3_limit_beats_timeout", state_o, 6);
    dwell(3'd6, 100, B_GRIP, n, hi);
    check("g3_idle", state_o, 0);

    // game 4: play window, then home timeout into FAULT
    lim_x = 1'b1; lim_y = 1'b0; lim_z = 1'b0;
    coin = 1'b1; step(); coin = 1'b0;
    check("g4_coin_play", state_o, 1);
    dwell(3'd1, 200, B_XF, n, hi);
`ifdef CLAW_PLAY_TIMER_EN
    check("g4_play_timeout_len", n, 40);
    check("g4_play_timeout_drop", state_o, 2);
`else
    check("g4_play_no_timeout", n, 200);
    check("g4_still_play", state_o, 1);
    btn_drop = 1'b1; repeat (3) step(); btn_drop = 1'b0;
    check("g4_drop_entry", state_o, 2);
`endif
    dwell(3'd2, 100, B_ZD, n, hi);
    check("g4_drop_len", n, 12);
    dwell(3'd3, 100, B_GRIP, n, hi);
    check("g4_grab_len", n, 8);
    lim_z = 1'b1;
    dwell(3'd4, 100, B_ZU, n, hi);
    check("g4_lift_len", n, 3);
    dwell(3'd5, 200, B_YB, n, hi);
    check("g4_home_timeout_len", n, 80);
    check("g4_home_y_bwd", hi, 80);
    check("g4_fault_state", state_o, 7);
    check("g4_fault_outs", outs, 8'h80);
    coin = 1'b1; btn_drop = 1'b1; btn_right = 1'b1;
    repeat (10) step();
    coin = 1'b0; btn_drop = 1'b0; btn_right = 1'b0;
    check("g4_fault_sticky", state_o, 7);
    check("g4_fault_sticky_outs", outs, 8'h80);
    reset = 1'b1; step(); reset = 1'b0;
    check("g4_reset_state", state_o, 0);
    check("g4_reset_outs", outs, 0);

    // game 5: reset during LIFT
    lim_x = 1'b0; lim_y = 1'b0; lim_z = 1'b0;
    coin = 1'b1; step(); coin = 1'b0;
    btn_drop = 1'b1; repeat (3) step(); btn_drop = 1'b0;
    check("g5_drop_entry", state_o, 2);
    dwell(3'd2, 100, B_ZD, n, hi);
    dwell(3'd3, 100, B_GRIP, n, hi);
    step();
    check("g5_lift_state", state_o, 4);
    check("g5_lift_outs", outs, 8'h60);
    reset = 1'b1; step(); reset = 1'b0;
    check("g5_reset_state", state_o, 0);
    check("g5_reset_outs", outs, 0);
    repeat (3) step();
    check("g5_stay_idle", state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/claw_game_sequencer.md
# claw_game_sequencer

Top-level game controller for the claw machine. It sequences the three `claw_movement` stepper axes (X left/right, Y forwards/backwards, Z up/down) and the gripper through one complete game. The sequence is: coin-in, timed user play, drop, grab, lift, return home, release. It replaces the direct button-to-motor wiring in the top level: buttons and limit switches enter this block, and per-axis forwards/backwards commands leave it toward the `claw_movement` instances.

## Interface
Parameters:
- `TICK_DIV`, 100000: `CLK100MHZ` cycles per timer tick (1 ms).
- `PLAY_TICKS`, 20000: user play window, in ticks.
- `DROP_TICKS`, 1500: duration of Z descent, in ticks.
- `GRIP_TICKS`, 500: gripper close and open settle time, in ticks.
- `HOME_TIMEOUT`, 10000: maximum ticks allowed in LIFT and in HOME.

Ports:
- `CLK100MHZ` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `coin` in 1: start request, level.
- `btn_left`, `btn_right`, `btn_fwd`, `btn_back`, `btn_drop` in 1 each: raw player buttons, asynchronous.
- `lim_x`, `lim_y`, `lim_z` in 1 each: home limit switches, active-high, asynchronous.
- `x_fwd`, `x_bwd`, `y_fwd`, `y_bwd`, `z_down`, `z_up` out 1 each: axis motion commands.
- `grip` out 1: 1 closes the claw.
- `state_o` out 3: current state encoding.
- `fault` out 1: home or lift timeout occurred.

## Operation
- All button and limit inputs pass through 2-flop synchronizers. All outputs are registered.
- Home direction is `x_bwd`, `y_bwd` and `z_up`.
- States and encodings: IDLE=0, PLAY=1, DROP=2, GRAB=3, LIFT=4, HOME=5, RELEASE=6, FAULT=7.
- IDLE: all outputs 0. `coin`=1 moves to PLAY.
- PLAY: button-to-output mapping is `btn_right`→`x_fwd`, `btn_left`→`x_bwd`, `btn_fwd`→`y_fwd`, `btn_back`→`y_bwd`.
  - If both buttons of one axis are pressed, both commands for that axis are 0.
  - `x_bwd` is gated off while `lim_x`=1. `y_bwd` is gated off while `lim_y`=1.
  - `btn_drop`=1 moves to DROP.
- DROP: `z_down`=1 for exactly `DROP_TICKS` ticks, then GRAB.
- GRAB: `grip`=1 for `GRIP_TICKS` ticks, then LIFT.
- LIFT: `grip`=1 and `z_up`=1 until `lim_z`=1, then HOME.
- HOME: `grip`=1. `x_bwd`=1 until `lim_x`=1 and `y_bwd`=1 until `lim_y`=1; each axis stops independently. When both limits are 1, move to RELEASE.
- RELEASE: `grip`=0 for `GRIP_TICKS` ticks, then IDLE.
- FAULT: all motion commands 0, `grip`=0, `fault`=1. Only `reset` exits FAULT.
- LIFT or HOME running `HOME_TIMEOUT` ticks without completing moves to FAULT.
- `coin` outside IDLE is ignored. `coin` held through RELEASE→IDLE starts a new game one cycle after IDLE is entered.
- Buttons are ignored outside PLAY.

## Timing
- Reset: on the first rising edge with `reset`=1:
  - state becomes IDLE;
  - all outputs become 0, including `grip` (any held prize is dropped);
  - `fault` becomes 0;
  - timers and synchronizers are cleared.
- Latency:
  - raw input to output change is 3 cycles (2 sync + 1 register);
  - a state transition is visible on `state_o` and the outputs in the same cycle.
- Timer:
  - the prescaler and the tick counter both clear on every state entry;
  - a timed state therefore lasts exactly N×`TICK_DIV` cycles, where N is that state's tick count.
- Simultaneous events:
  - `btn_drop` arriving in the cycle the play timer expires: DROP, same result either way.
  - Limit reached in the cycle the timeout expires: the limit wins and the normal transition is taken.
- A limit already 1 on entry to HOME or LIFT: that axis command is never asserted. If all required limits are already 1, the block leaves the state after 1 cycle.

## Configuration
- `CLAW_PLAY_TIMER_EN` defined: PLAY also ends, moving to DROP, after `PLAY_TICKS` ticks.
- Not defined: PLAY ends only on `btn_drop`. `PLAY_TICKS` is unused, and no play-timer logic is synthesized.

## Structure
- Package `claw_pkg` holds:
  - the 3-bit state enum and its encodings;
  - the default values of the five parameters;
  - a localparam for the synchronizer depth (2).
- Sub-module `claw_timer`:
  - contains the `TICK_DIV` prescaler plus a tick counter, with a synchronous clear;
  - exposes `elapsed_ticks`;
  - is instantiated once and shared by all states, cleared on state change.

## Test plan
Bench parameters: `TICK_DIV`=4, `PLAY_TICKS`=10, `DROP_TICKS`=3, `GRIP_TICKS`=2, `HOME_TIMEOUT`=20.
- Full game path:
  - Stimulus: `coin` pulse, hold `btn_right` 8 cycles, then `btn_drop`, then assert `lim_z`, `lim_x` and `lim_y` in order after the first 5 LIFT cycles.
  - Response: `state_o` steps 0→1→2→3→4→5→6→0; `x_fwd` high during PLAY; `z_down` high exactly 12 cycles; `grip` high from GRAB through HOME; 8-cycle RELEASE.
- Conflict and limit gating:
  - Stimulus: in PLAY, press `btn_left` and `btn_right` together; then press `btn_left` with `lim_x`=1.
  - Response: `x_fwd`=`x_bwd`=0 in both cases.
- Play timeout:
  - With `CLAW_PLAY_TIMER_EN` and no drop press: DROP is entered exactly 40 cycles after PLAY entry.
  - Without the macro: the block is still in PLAY after 200 cycles.
- Home timeout:
  - Stimulus: in HOME, hold `lim_y`=0 indefinitely.
  - Response: `state_o`=7 after 80 cycles; `fault`=1; `grip`=0; all motion 0; `coin` ignored until `reset`.
- Reset mid-operation:
  - Stimulus: `reset`=1 for 1 cycle during LIFT.
  - Response: next edge gives `state_o`=0 with `grip`, `z_up` and `fault` all 0.
- Coin outside IDLE:
  - Stimulus: `coin` pulsed during DROP.
  - Response: no effect on the sequence; the game returns to IDLE and stays there.
